// File: rtl/serial_mod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_mod_pkg
// Purpose  : Shared state encoding and stream-mode constants for the serial
//            modulo checker.
// Revision : 1.0 - initial release
// ============================================================================
package serial_mod_pkg;

    // IDLE: unconfigured or bad divisor; ARMED: configured, empty frame;
    // ACCUM: at least one bit folded into the remainder.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_mod_step.sv
`default_nettype none
// ============================================================================
// Module   : serial_mod_step
// Purpose  : One conditional-subtract reduction step. The operand is known to
//            be below 2*div, so one subtract yields operand mod div.
// Revision : 1.0 - initial release
// ============================================================================
module serial_mod_step #(
    parameter int DIV_W = 4
) (
    input  logic [DIV_W:0]   operand,
    input  logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] result
);

    logic             w_ge;
    logic [DIV_W-1:0] w_sub;

    // The low DIV_W bits of the difference are exact because the true result
    // is below div whenever the subtract is selected.
    assign w_ge   = (operand >= {1'b0, div});
    assign w_sub  = operand[DIV_W-1:0] - div;
    assign result = w_ge ? w_sub : operand[DIV_W-1:0];

endmodule
`default_nettype wire

// File: rtl/serial_mod_checker.sv
`default_nettype none
// ============================================================================
// Module   : serial_mod_checker
// Purpose  : Tracks the running remainder of a serial bit stream modulo a
//            runtime-programmable divisor, MSB-first or LSB-first, with frame
//            starts and a saturating bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter int DIV_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_lsb_first,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             frame_start,
    output logic [DIV_W-1:0] rem_out,
    output logic             divisible,
    output logic [CNT_W-1:0] bit_count,
    output logic             cfg_err
);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_mode;
    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_weight;
    logic [CNT_W-1:0] r_count;
    logic             r_divisible;
    logic             r_cfg_err;

    logic             w_clear;
    logic [DIV_W-1:0] w_rem_base;
    logic [DIV_W-1:0] w_weight_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic [DIV_W:0]   w_msb_operand;
    logic [DIV_W:0]   w_lsb_operand;
    logic [DIV_W:0]   w_weight_operand;
    logic [DIV_W-1:0] w_msb_rem;
    logic [DIV_W-1:0] w_lsb_rem;
    logic [DIV_W-1:0] w_weight_next;
    logic [DIV_W-1:0] w_rem_next;

    // Select the frame the incoming bit applies to (fresh or running) and form
    // the pre-reduction operands for both stream orders.
    always_comb begin
        w_clear          = frame_start || (r_state == ARMED);
        w_rem_base       = w_clear ? '0 : r_rem;
        w_weight_base    = w_clear ? ((r_div == DIV_W'(1)) ? '0 : DIV_W'(1)) : r_weight;
        w_cnt_base       = w_clear ? '0 : r_count;
        w_cnt_next       = (&w_cnt_base) ? w_cnt_base : (w_cnt_base + CNT_W'(1));
        w_msb_operand    = {w_rem_base, bit_in};
        w_lsb_operand    = {1'b0, w_rem_base} + (bit_in ? {1'b0, w_weight_base} : '0);
        w_weight_operand = {w_weight_base, 1'b0};
        w_rem_next       = (r_mode == MODE_LSB) ? w_lsb_rem : w_msb_rem;
    end

    serial_mod_step #(.DIV_W(DIV_W)) u_step_msb (
        .operand (w_msb_operand),
        .div     (r_div),
        .result  (w_msb_rem)
    );

    serial_mod_step #(.DIV_W(DIV_W)) u_step_lsb (
        .operand (w_lsb_operand),
        .div     (r_div),
        .result  (w_lsb_rem)
    );

    serial_mod_step #(.DIV_W(DIV_W)) u_step_weight (
        .operand (w_weight_operand),
        .div     (r_div),
        .result  (w_weight_next)
    );

    // Control FSM and datapath registers; configuration beats data in a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_mode      <= MODE_MSB;
            r_rem       <= '0;
            r_weight    <= '0;
            r_count     <= '0;
            r_divisible <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else if (cfg_load) begin
            r_rem       <= '0;
            r_count     <= '0;
            r_divisible <= 1'b0;
            if (cfg_div == '0) begin
                r_cfg_err <= 1'b1;
                r_state   <= IDLE;
                r_weight  <= '0;
            end else begin
                r_cfg_err <= 1'b0;
                r_state   <= ARMED;
                r_div     <= cfg_div;
                r_mode    <= cfg_lsb_first;
                r_weight  <= (cfg_div == DIV_W'(1)) ? '0 : DIV_W'(1);
            end
        end else if (bit_valid && (r_state != IDLE)) begin
            r_state     <= ACCUM;
            r_rem       <= w_rem_next;
            r_divisible <= (w_rem_next == '0);
            r_count     <= w_cnt_next;
            if (r_mode == MODE_LSB) begin
                r_weight <= w_weight_next;
            end
        end
    end

    assign rem_out   = r_rem;
    assign divisible = r_divisible;
    assign bit_count = r_count;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_mod_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_mod_checker
// Purpose  : Directed self-checking bench for serial_mod_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_mod_checker;

    logic       clk;
    logic       rst_n;
    logic       cfg_load;
    logic [3:0] cfg_div;
    logic       cfg_lsb_first;
    logic       bit_valid;
    logic       bit_in;
    logic       frame_start;
    logic [3:0] rem_out;
    logic       divisible;
    logic [7:0] bit_count;
    logic       cfg_err;
    logic [3:0] rem_out_s;
    logic       divisible_s;
    logic [2:0] bit_count_s;
    logic       cfg_err_s;

    int checks = 0;
    int errors = 0;

    serial_mod_checker #(.DIV_W(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_load      (cfg_load),
        .cfg_div       (cfg_div),
        .cfg_lsb_first (cfg_lsb_first),
        .bit_valid     (bit_valid),
        .bit_in        (bit_in),
        .frame_start   (frame_start),
        .rem_out       (rem_out),
        .divisible     (divisible),
        .bit_count     (bit_count),
        .cfg_err       (cfg_err)
    );

    serial_mod_checker #(.DIV_W(4), .CNT_W(3)) dut_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_load      (cfg_load),
        .cfg_div       (cfg_div),
        .cfg_lsb_first (cfg_lsb_first),
        .bit_valid     (bit_valid),
        .bit_in        (bit_in),
        .frame_start   (frame_start),
        .rem_out       (rem_out_s),
        .divisible     (divisible_s),
        .bit_count     (bit_count_s),
        .cfg_err       (cfg_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic cl, input logic [3:0] d, input logic lsb,
                       input logic bv, input logic b, input logic fs);
        cfg_load      = cl;
        cfg_div       = d;
        cfg_lsb_first = lsb;
        bit_valid     = bv;
        bit_in        = b;
        frame_start   = fs;
        @(posedge clk);
        #1;
        cfg_load    = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] d, input logic lsb);
        cyc(1'b1, d, lsb, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sbit(input logic b, input logic fs);
        cyc(1'b0, cfg_div, cfg_lsb_first, 1'b1, b, fs);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_load = 1'b0; cfg_div = '0; cfg_lsb_first = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rem", 32'(rem_out), 32'd0);
        chk("reset_div", 32'(divisible), 32'd0);
        chk("reset_cnt", 32'(bit_count), 32'd0);
        chk("reset_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // bit_valid while unconfigured is ignored
        sbit(1'b1, 1'b1);
        chk("idle_rem", 32'(rem_out), 32'd0);
        chk("idle_cnt", 32'(bit_count), 32'd0);

        // MSB-first, div 5, 1010 = 10
        cfg(4'd5, 1'b0);
        chk("armed_div", 32'(divisible), 32'd0);
        sbit(1'b1, 1'b1); chk("msb5_r1", 32'(rem_out), 32'd1); chk("msb5_d1", 32'(divisible), 32'd0);
        sbit(1'b0, 1'b0); chk("msb5_r2", 32'(rem_out), 32'd2); chk("msb5_d2", 32'(divisible), 32'd0);
        sbit(1'b1, 1'b0); chk("msb5_r3", 32'(rem_out), 32'd0); chk("msb5_d3", 32'(divisible), 32'd1);
        sbit(1'b0, 1'b0); chk("msb5_r4", 32'(rem_out), 32'd0); chk("msb5_d4", 32'(divisible), 32'd1);
        chk("msb5_cnt", 32'(bit_count), 32'd4);

        // frame_start without bit_valid has no effect
        cyc(1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("fs_novalid_cnt", 32'(bit_count), 32'd4);

        // LSB-first, div 3, bits 0,1,1 = 6
        cfg(4'd3, 1'b1);
        sbit(1'b0, 1'b1); chk("lsb3_r1", 32'(rem_out), 32'd0);
        sbit(1'b1, 1'b0); chk("lsb3_r2", 32'(rem_out), 32'd2);
        sbit(1'b1, 1'b0); chk("lsb3_r3", 32'(rem_out), 32'd0);
        chk("lsb3_div", 32'(divisible), 32'd1);
        chk("lsb3_cnt", 32'(bit_count), 32'd3);

        // divisor 0 -> error, bits ignored
        cfg(4'd0, 1'b0);
        chk("div0_err", 32'(cfg_err), 32'd1);
        chk("div0_rem", 32'(rem_out), 32'd0);
        for (int i = 0; i < 4; i++) sbit(1'b1, (i == 0));
        chk("div0_rem_after", 32'(rem_out), 32'd0);
        chk("div0_cnt_after", 32'(bit_count), 32'd0);
        chk("div0_div_after", 32'(divisible), 32'd0);
        cfg(4'd7, 1'b0);
        chk("div7_err_clr", 32'(cfg_err), 32'd0);

        // div 15, MSB-first 11111111 = 255 = 17*15
        cfg(4'd15, 1'b0);
        for (int i = 0; i < 8; i++) sbit(1'b1, (i == 0));
        chk("d15_rem", 32'(rem_out), 32'd0);
        chk("d15_div", 32'(divisible), 32'd1);
        sbit(1'b1, 1'b1);
        chk("d15_fs_rem", 32'(rem_out), 32'd1);
        chk("d15_fs_cnt", 32'(bit_count), 32'd1);

        // Counter saturation on the CNT_W=3 instance, div 2, nine bits
        cfg(4'd2, 1'b0);
        for (int i = 0; i < 7; i++) sbit(1'b1, (i == 0));
        chk("sat_cnt7", 32'(bit_count_s), 32'd7);
        sbit(1'b1, 1'b0);
        sbit(1'b1, 1'b0);
        chk("sat_cnt9_small", 32'(bit_count_s), 32'd7);
        chk("sat_cnt9_big", 32'(bit_count), 32'd9);
        chk("sat_rem", 32'(rem_out_s), 32'd1);

        // Asynchronous reset mid-frame
        cfg(4'd5, 1'b0);
        sbit(1'b1, 1'b1);
        sbit(1'b1, 1'b0);
        chk("pre_rst_rem", 32'(rem_out), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rem", 32'(rem_out), 32'd0);
        chk("arst_cnt", 32'(bit_count), 32'd0);
        chk("arst_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // cfg_load with a coincident bit drops the bit and re-arms
        cfg(4'd5, 1'b0);
        sbit(1'b1, 1'b1);
        sbit(1'b1, 1'b0);
        chk("pre_cl_rem", 32'(rem_out), 32'd3);
        cyc(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("cl_bv_rem", 32'(rem_out), 32'd0);
        chk("cl_bv_cnt", 32'(bit_count), 32'd0);
        chk("cl_bv_div", 32'(divisible), 32'd0);
        sbit(1'b1, 1'b0);
        chk("cl_next_rem", 32'(rem_out), 32'd1);
        chk("cl_next_cnt", 32'(bit_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
